switch_allocator: RTL and testbench

// Per-output wormhole switch allocator and credit tracker for the 5-port mesh router (N,E,W,S,L).

---
 rtl/noc_pkg.sv | 34 +++
 rtl/rr_arbiter5.sv | 41 ++++
 rtl/switch_allocator.sv | 147 ++++++++++++++
 tb/tb_switch_allocator.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared port, direction and flit-type definitions for the 5-port mesh router.
package noc_pkg;

  typedef enum logic [2:0] {
    PORT_L = 3'd0,
    PORT_S = 3'd1,
    PORT_W = 3'd2,
    PORT_E = 3'd3,
    PORT_N = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_e;

  localparam logic [5:0] DIR_IDLE = 6'b100000;
  localparam logic [5:0] DIR_N    = 6'b010000;
  localparam logic [5:0] DIR_E    = 6'b001000;
  localparam logic [5:0] DIR_W    = 6'b000100;
  localparam logic [5:0] DIR_S    = 6'b000010;
  localparam logic [5:0] DIR_L    = 6'b000001;

  localparam logic [2:0] CREDIT_DISABLED = 3'b110;
  localparam logic [2:0] CREDIT_LOCAL    = 3'b111;

  // Round-robin order is N -> E -> W -> S -> L -> N, i.e. descending index.
  function automatic port_e next_port(input port_e p);
    return (p == PORT_L) ? PORT_N : port_e'(p - 3'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Five-way round-robin arbiter: grant goes to the first requester at or after
// the pointer; the pointer moves past the winner when update is strobed.
module rr_arbiter5
  import noc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic       update,
  output logic [4:0] grant
);

  port_e ptr_q;
  port_e winner;
  port_e cur;
  logic  found;

  always_comb begin
    grant  = '0;
    winner = ptr_q;
    found  = 1'b0;
    cur    = ptr_q;
    for (int unsigned k = 0; k < 5; k++) begin
      if (!found && req[cur]) begin
        grant[cur] = 1'b1;
        winner     = cur;
        found      = 1'b1;
      end
      cur = next_port(cur);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PORT_N;
    end else if (update && found) begin
      ptr_q <= next_port(winner);
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator with downstream credit tracking.
// One rr_arbiter5 per output; locks, owners and credit counters are kept here.
module switch_allocator
  import noc_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 5,
  parameter logic [4:0]  PORT_EN   = 5'b11111
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  north_dir_i,
  input  logic [5:0]  east_dir_i,
  input  logic [5:0]  west_dir_i,
  input  logic [5:0]  south_dir_i,
  input  logic [5:0]  local_dir_i,
  input  logic [9:0]  flit_type_i,
  input  logic [4:0]  counter_minus_i,
  input  logic [4:0]  credit_return_i,
  output logic        arb_o,
  output logic [4:0]  filter_o,
  output logic [14:0] credit_all_o,
  output logic [4:0]  lock_o
);

  logic [5:0] dir [5];
  flit_e      ftype [5];
  logic [4:0] is_head, is_head_only, is_tail;
  logic [4:0] req_mat [5];  // [output][input]
  logic [4:0] arb_req [5];
  logic [4:0] grant [5];
  logic [4:0] sel [5];
  logic [4:0] pass [5];
  logic [4:0] arb_upd, lock_set, lock_clr;
  logic [4:0] credit_ok;
  logic [4:0] blocked;

  logic [4:0] locked_q;
  logic [4:0] owner_q [5];
  logic [2:0] credit_q [4:1];

  assign dir[PORT_N] = north_dir_i;
  assign dir[PORT_E] = east_dir_i;
  assign dir[PORT_W] = west_dir_i;
  assign dir[PORT_S] = south_dir_i;
  assign dir[PORT_L] = local_dir_i;

  always_comb begin
    is_head      = '0;
    is_head_only = '0;
    is_tail      = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      ftype[i]        = flit_e'(flit_type_i[2*i +: 2]);
      is_head[i]      = (ftype[i] == FLIT_HEAD) || (ftype[i] == FLIT_SINGLE);
      is_head_only[i] = (ftype[i] == FLIT_HEAD);
      is_tail[i]      = (ftype[i] == FLIT_TAIL);
    end
    for (int unsigned o = 0; o < 5; o++) begin
      req_mat[o] = '0;
      for (int unsigned i = 0; i < 5; i++) begin
        req_mat[o][i] = dir[i][o] & ~dir[i][5];
      end
    end
  end

  always_comb begin
    credit_ok    = '1;
    for (int unsigned o = 1; o < 5; o++) begin
      credit_ok[o] = (credit_q[o] != '0);
    end
  end

  for (genvar o = 0; o < 5; o++) begin : g_out
    // Only head/single flits may compete for an idle output.
    assign arb_req[o] = locked_q[o] ? '0 : (req_mat[o] & is_head);

    rr_arbiter5 u_arb (
      .clk    (clk_i),
      .rst    (rst_i),
      .req    (arb_req[o]),
      .update (arb_upd[o]),
      .grant  (grant[o])
    );

    assign sel[o]      = locked_q[o] ? (owner_q[o] & req_mat[o]) : grant[o];
    assign pass[o]     = credit_ok[o] ? sel[o] : '0;
    assign arb_upd[o]  = !locked_q[o] && counter_minus_i[o] && (grant[o] != '0);
    assign lock_set[o] = arb_upd[o] && ((grant[o] & is_head_only) != '0);
    assign lock_clr[o] = locked_q[o] && counter_minus_i[o]
                         && ((owner_q[o] & req_mat[o] & is_tail) != '0);

    a_no_body_to_idle: assert property (@(posedge clk_i) disable iff (rst_i)
      !(!locked_q[o] && ((req_mat[o] & ~is_head) != '0)));
  end

  for (genvar o = 1; o < 5; o++) begin : g_cred_chk
    if (PORT_EN[o]) begin : g_en
      a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(counter_minus_i[o] && !credit_return_i[o] && credit_q[o] == '0));
      a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(credit_return_i[o] && !counter_minus_i[o] && credit_q[o] == 3'(BUF_DEPTH)));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      locked_q <= '0;
      for (int unsigned o = 0; o < 5; o++) begin
        owner_q[o] <= '0;
      end
      for (int unsigned o = 1; o < 5; o++) begin
        credit_q[o] <= PORT_EN[o] ? 3'(BUF_DEPTH) : CREDIT_DISABLED;
      end
    end else begin
      for (int unsigned o = 0; o < 5; o++) begin
        if (lock_set[o]) begin
          locked_q[o] <= 1'b1;
          owner_q[o]  <= grant[o];
        end else if (lock_clr[o]) begin
          locked_q[o] <= 1'b0;
        end
      end
      // Underflow and overflow saturate; simultaneous minus and return cancel.
      for (int unsigned o = 1; o < 5; o++) begin
        if (PORT_EN[o]) begin
          case ({counter_minus_i[o], credit_return_i[o]})
            2'b10:   if (credit_q[o] != '0) credit_q[o] <= credit_q[o] - 3'd1;
            2'b01:   if (credit_q[o] != 3'(BUF_DEPTH)) credit_q[o] <= credit_q[o] + 3'd1;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    blocked = '0;
    for (int unsigned o = 0; o < 5; o++) begin
      blocked = blocked | (req_mat[o] & ~pass[o]);
    end
  end

  assign filter_o     = rst_i ? '0 : blocked;
  assign arb_o        = |filter_o;
  assign lock_o       = locked_q;
  assign credit_all_o = {credit_q[4], credit_q[3], credit_q[2], credit_q[1], CREDIT_LOCAL};

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios followed by randomized
// wormhole traffic, compared against a packet-level reference model.
module tb_switch_allocator;
  import noc_pkg::*;

  localparam int unsigned BUF = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  dir [5];       // by position: 0=N 1=E 2=W 3=S 4=L
  logic [1:0]  ft [5];
  logic [4:0]  minus = '0;
  logic [4:0]  ret = '0;
  logic [4:0]  ret2 = '0;
  logic [9:0]  ftv;
  logic        arb, arb2;
  logic [4:0]  filt, filt2, lock, lock2;
  logic [14:0] cred_all, cred_all2;

  assign ftv = {ft[0], ft[1], ft[2], ft[3], ft[4]};

  always #5 clk = ~clk;

  switch_allocator #(.BUF_DEPTH(BUF), .PORT_EN(5'b11111)) dut (
    .clk_i(clk), .rst_i(rst),
    .north_dir_i(dir[0]), .east_dir_i(dir[1]), .west_dir_i(dir[2]),
    .south_dir_i(dir[3]), .local_dir_i(dir[4]),
    .flit_type_i(ftv), .counter_minus_i(minus), .credit_return_i(ret),
    .arb_o(arb), .filter_o(filt), .credit_all_o(cred_all), .lock_o(lock)
  );

  switch_allocator #(.BUF_DEPTH(BUF), .PORT_EN(5'b01111)) dut_edge (
    .clk_i(clk), .rst_i(rst),
    .north_dir_i(DIR_IDLE), .east_dir_i(DIR_IDLE), .west_dir_i(DIR_IDLE),
    .south_dir_i(DIR_IDLE), .local_dir_i(DIR_IDLE),
    .flit_type_i(10'b0), .counter_minus_i(5'b0), .credit_return_i(ret2),
    .arb_o(arb2), .filter_o(filt2), .credit_all_o(cred_all2), .lock_o(lock2)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model, indexed by position N=0..L=4.
  int owner [5];
  int ptr [5];
  int cred [5];
  int win [5];
  int rq [5];

  function automatic logic [5:0] dir_to(input int q);
    logic [5:0] d = '0;
    d[4-q] = 1'b1;
    return d;
  endfunction

  function automatic void model_reset();
    for (int q = 0; q < 5; q++) begin
      owner[q] = -1;
      ptr[q]   = 0;
      cred[q]  = (q == 4) ? 7 : int'(BUF);
    end
  endfunction

  function automatic void model_eval();
    int cand;
    for (int i = 0; i < 5; i++) begin
      rq[i] = -1;
      if (!dir[i][5])
        for (int q = 4; q >= 0; q--) if (dir[i][4-q]) rq[i] = q;
    end
    for (int q = 0; q < 5; q++) begin
      cand = -1;
      if (owner[q] >= 0) begin
        if (rq[owner[q]] == q) cand = owner[q];
      end else begin
        for (int k = 0; k < 5; k++) begin
          int i;
          i = (ptr[q] + k) % 5;
          if (cand < 0 && rq[i] == q && (ft[i] == FLIT_HEAD || ft[i] == FLIT_SINGLE)) cand = i;
        end
      end
      win[q] = (cand >= 0 && cred[q] > 0) ? cand : -1;
    end
  endfunction

  function automatic logic [4:0] exp_filter();
    logic [4:0] f = '0;
    for (int i = 0; i < 5; i++)
      if (rq[i] >= 0 && win[rq[i]] != i) f[4-i] = 1'b1;
    return f;
  endfunction

  function automatic logic [4:0] exp_lock();
    logic [4:0] l = '0;
    for (int q = 0; q < 5; q++) l[4-q] = (owner[q] >= 0);
    return l;
  endfunction

  function automatic logic [14:0] exp_cred();
    logic [14:0] v = '0;
    for (int q = 0; q < 5; q++) v = {v[11:0], 3'(cred[q])};
    return v;
  endfunction

  function automatic void model_commit();
    for (int q = 0; q < 5; q++) begin
      if (minus[4-q] && win[q] >= 0) begin
        int i;
        i = win[q];
        if (owner[q] < 0) begin
          ptr[q] = (i + 1) % 5;
          if (ft[i] == FLIT_HEAD) owner[q] = i;
        end else if (ft[i] == FLIT_TAIL) begin
          owner[q] = -1;
        end
      end
    end
    for (int q = 0; q < 4; q++) begin
      if (minus[4-q] && !ret[4-q] && cred[q] > 0) cred[q]--;
      else if (ret[4-q] && !minus[4-q] && cred[q] < int'(BUF)) cred[q]++;
    end
  endfunction

  task automatic idle_all();
    for (int i = 0; i < 5; i++) begin
      dir[i] = DIR_IDLE;
      ft[i]  = FLIT_BODY;
    end
  endtask

  // One cycle: the datapath sends every winner selected by send_mask.
  task automatic step(input logic [4:0] send_mask, input logic [4:0] r, input string tag);
    logic [4:0] ef;
    model_eval();
    minus = '0;
    for (int q = 0; q < 5; q++) if (win[q] >= 0 && send_mask[4-q]) minus[4-q] = 1'b1;
    ret = r;
    ef  = exp_filter();
    @(negedge clk);
    check($sformatf("%s.filter", tag), 32'(filt), 32'(ef));
    check($sformatf("%s.arb", tag), 32'(arb), 32'(|ef));
    check($sformatf("%s.lock", tag), 32'(lock), 32'(exp_lock()));
    check($sformatf("%s.credit", tag), 32'(cred_all), 32'(exp_cred()));
    @(posedge clk);
    model_commit();
    #1;
    minus = '0;
    ret   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    minus = '0;
    ret = '0;
    idle_all();
    dir[0] = dir_to(1); ft[0] = FLIT_HEAD;
    dir[2] = dir_to(1); ft[2] = FLIT_HEAD;
    #1 rst = 1'b1;
    #2;
    model_reset();
    check("rst.filter", 32'(filt), 32'(5'b00000));
    check("rst.arb", 32'(arb), 32'(1'b0));
    check("rst.lock", 32'(lock), 32'(5'b00000));
    check("rst.credit", 32'(cred_all), 32'({3'b101, 3'b101, 3'b101, 3'b101, 3'b111}));
    @(negedge clk);
    rst = 1'b0;
    idle_all();
    @(posedge clk);
    #1;
  endtask

  bit         sown [5];
  int         sdst [5];
  int         srem [5];
  logic [4:0] rot_exp [5];
  logic [4:0] rr;

  initial begin
    idle_all();
    do_reset();
    check("edge.rst_credit", 32'(cred_all2), 32'({3'b110, 3'b101, 3'b101, 3'b101, 3'b111}));
    check("edge.rst_arb", 32'(arb2), 32'(1'b0));

    // N and W heads contend for E; N locks, sends tail, then W wins.
    idle_all();
    dir[0] = dir_to(1); ft[0] = FLIT_HEAD;
    dir[2] = dir_to(1); ft[2] = FLIT_HEAD;
    #1 check("contend.n_wins", 32'(filt), 32'(5'b00100));
    step('1, '0, "contend");
    ft[0] = FLIT_TAIL;
    step('1, '0, "n_tail");
    dir[0] = DIR_IDLE;
    #1 check("contend.w_wins", 32'(filt), 32'(5'b00000));
    step('1, '0, "w_head");
    ft[2] = FLIT_TAIL;
    step('1, '0, "w_tail");

    // Single flits from N, W, S, L to E rotate N,W,S,L,N.
    do_reset();
    idle_all();
    for (int i = 0; i < 5; i++) if (i != 1) begin dir[i] = dir_to(1); ft[i] = FLIT_SINGLE; end
    rot_exp = '{5'b00111, 5'b10011, 5'b10101, 5'b10110, 5'b00111};
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("rot%0d.winner", k), 32'(filt), 32'(rot_exp[k]));
      step('1, 5'b01000, "rot");
    end

    // S owns E mid-packet; L head waits until S's tail has gone.
    do_reset();
    idle_all();
    dir[3] = dir_to(1); ft[3] = FLIT_HEAD;
    step('1, '0, "s_head");
    dir[4] = dir_to(1); ft[4] = FLIT_HEAD;
    ft[3] = FLIT_BODY;
    #1 check("hold.body", 32'(filt), 32'(5'b00001));
    check("hold.lock_e", 32'(lock[3]), 32'(1'b1));
    step('1, '0, "s_body");
    ft[3] = FLIT_TAIL;
    #1 check("hold.tail", 32'(filt), 32'(5'b00001));
    step('1, '0, "s_tail");
    dir[3] = DIR_IDLE;
    #1 check("hold.l_wins", 32'(filt), 32'(5'b00000));
    step('1, '0, "l_head");
    ft[4] = FLIT_TAIL;
    step('1, '0, "l_tail");

    // Drain E to zero, return credits, then cancel minus against return.
    do_reset();
    idle_all();
    dir[0] = dir_to(1); ft[0] = FLIT_SINGLE;
    for (int k = 0; k < 4; k++) step('1, '0, "drain");
    #1 check("drain.e_one", 32'(cred_all[11:9]), 32'(3'd1));
    step('1, '0, "drain_last");
    #1 check("drain.e_zero", 32'(cred_all[11:9]), 32'(3'd0));
    check("drain.blocked", 32'(filt), 32'(5'b10000));
    step('1, 5'b01000, "ret");
    #1 check("ret.e_one", 32'(cred_all[11:9]), 32'(3'd1));
    check("ret.unblocked", 32'(filt), 32'(5'b00000));
    step('0, 5'b01000, "ret2");
    step('0, 5'b01000, "ret3");
    #1 check("ret.e_three", 32'(cred_all[11:9]), 32'(3'd3));
    step('1, 5'b01000, "cancel");
    #1 check("cancel.e_three", 32'(cred_all[11:9]), 32'(3'd3));

    // Reset in the middle of a packet from N through W.
    idle_all();
    dir[0] = dir_to(2); ft[0] = FLIT_HEAD;
    step('1, '0, "mid_head");
    ft[0] = FLIT_BODY;
    check("mid.locked", 32'(lock), 32'(5'b00100));
    do_reset();

    // A disabled edge port ignores credit returns.
    ret2 = 5'b10000;
    @(posedge clk);
    #1 ret2 = '0;
    check("edge.held", 32'(cred_all2), 32'({3'b110, 3'b101, 3'b101, 3'b101, 3'b111}));
    check("edge.arb", 32'(arb2), 32'(1'b0));

    // Randomized wormhole traffic from five protocol-abiding senders.
    idle_all();
    for (int i = 0; i < 5; i++) begin sown[i] = 1'b0; sdst[i] = 0; srem[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (sown[i]) begin
          if ($urandom_range(0, 3) != 0) begin
            dir[i] = dir_to(sdst[i]);
            ft[i]  = (srem[i] == 0) ? FLIT_TAIL : FLIT_BODY;
          end else begin
            dir[i] = DIR_IDLE; ft[i] = FLIT_BODY;
          end
        end else if ($urandom_range(0, 2) != 0) begin
          dir[i] = dir_to(int'($urandom_range(0, 4)));
          ft[i]  = ($urandom_range(0, 1) != 0) ? FLIT_HEAD : FLIT_SINGLE;
        end else begin
          dir[i] = DIR_IDLE; ft[i] = FLIT_BODY;
        end
      end
      rr = '0;
      for (int q = 0; q < 4; q++) if (cred[q] < int'(BUF) && $urandom_range(0, 3) == 0) rr[4-q] = 1'b1;
      step(5'($urandom) | 5'($urandom), rr, "rand");
      for (int q = 0; q < 5; q++) begin
        if (win[q] >= 0 && minus[4-q] == 1'b0) continue;
      end
    end
    idle_all();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Sender bookkeeping follows what actually left on each edge.
  always @(posedge clk) begin
    if (!rst) begin
      for (int q = 0; q < 5; q++) begin
        if (minus[4-q] && win[q] >= 0) begin
          if (ft[win[q]] == FLIT_HEAD && !sown[win[q]]) begin
            sown[win[q]] = 1'b1;
            sdst[win[q]] = q;
            srem[win[q]] = int'($urandom_range(0, 2));
          end else if (ft[win[q]] == FLIT_BODY && sown[win[q]]) begin
            srem[win[q]] = srem[win[q]] - 1;
          end else if (ft[win[q]] == FLIT_TAIL) begin
            sown[win[q]] = 1'b0;
          end
        end
      end
    end
  end

endmodule
